uart_fifo_loop_param: RTL and testbench

Parametrised UART loopback: a serial receiver deserialises 8N1 (or 8E1/8O1) frames from `rx`, stores the valid bytes in a synchronous FIFO, and a serial transmitter re-sends them on `tx` in arrival order. It is the next generation of the fixed 9600-baud, 8-bit FIFO loop, with these additions:
- configurable clock/baud, data width and FIFO depth;
- a transmit-gate input, so bursts can be buffered and released later;
- frame/parity error reporting and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_fifo_loop_param.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_loop_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART FIFO loopback.
// Holds the RX/TX state encodings, the baud divider helper and the sync depth.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam int SYNC_STAGES = 2;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
// Ports: wr_en_i/wr_data_i push, rd_en_i pop, rd_data_o shows the head word,
// full_o/empty_o/count_o report occupancy. DEPTH must be a power of two.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_rd   = rd_en_i & ~empty_o;
    // A write at full is accepted only when a read frees a slot the same cycle.
    assign do_wr   = wr_en_i & (~full_o | do_rd);

    always_comb begin
        count_d = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/uart_fifo_loop_param.sv
// UART loopback: RX deserialiser -> sync FIFO -> TX serialiser, in order.
// Ports: rx/tx serial lines, tx_en gate, ovf_clr, fifo_count, overflow,
// frame_err, parity_err. Define UART_PARITY_EN to add a parity bit.
module uart_fifo_loop_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    input  logic                        tx_en,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        frame_err,
    output logic                        parity_err
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] DIV_M1   = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF = CW'(BAUD_DIV / 2);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = 1'(PARITY_ODD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;

    rx_state_e              rx_st_q;
    logic [CW-1:0]          rx_cnt_q;
    logic [3:0]             rx_bit_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   push_q;
    logic                   frame_err_q;

    tx_state_e              tx_st_q;
    logic [CW-1:0]          tx_cnt_q;
    logic [3:0]             tx_bit_q;
    logic [DATA_BITS-1:0]   tx_sh_q;
    logic                   tx_q;
    logic                   tx_load;

    logic                   overflow_q;
    logic                   ovf_set;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

`ifdef UART_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
    logic tx_par_q;
    assign parity_err = parity_err_q;
`else
    logic unused_odd;
    assign unused_odd = ODD_BIT;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q     <= RX_IDLE;
            rx_prev_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_data_q   <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q   <= rx_s;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            unique case (rx_st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_cnt_q <= DIV_HALF;
                        rx_st_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (!rx_s) begin
                            rx_st_q  <= RX_DATA;
                            rx_cnt_q <= DIV_M1;
                            rx_bit_q <= '0;
`ifdef UART_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end else begin
                            rx_st_q <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_data_q <= {rx_s, rx_data_q[DATA_BITS-1:1]};
                        rx_cnt_q  <= DIV_M1;
                        if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_st_q <= RX_PARITY;
`else
                            rx_st_q <= RX_STOP;
`endif
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_PARITY: begin
`ifdef UART_PARITY_EN
                    if (rx_cnt_q == '0) begin
                        par_bad_q <= (^rx_data_q) ^ rx_s ^ ODD_BIT;
                        rx_cnt_q  <= DIV_M1;
                        rx_st_q   <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
`else
                    rx_st_q <= RX_IDLE;
`endif
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        frame_err_q <= ~rx_s;
`ifdef UART_PARITY_EN
                        parity_err_q <= par_bad_q;
                        push_q       <= rx_s & ~par_bad_q;
`else
                        push_q       <= rx_s;
`endif
                        // A low stop bit may be a break; wait for idle line.
                        rx_st_q <= rx_s ? RX_IDLE : RX_BREAK;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) rx_st_q <= RX_IDLE;
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    // The end of a stop bit doubles as an idle slot so bursts run gap-free.
    assign tx_load = tx_en & ~fifo_empty &
                     ((tx_st_q == TX_IDLE) |
                      ((tx_st_q == TX_STOP) & (tx_cnt_q == '0)));

    assign ovf_set = push_q & fifo_full & ~tx_load;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push_q),
        .wr_data_i (rx_data_q),
        .rd_en_i   (tx_load),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow_q <= 1'b0;
        else if (ovf_set) overflow_q <= 1'b1;
        else if (ovf_clr) overflow_q <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else begin
            if (tx_load) begin
                tx_sh_q  <= fifo_rd_data;
                tx_q     <= 1'b0;
                tx_cnt_q <= DIV_M1;
                tx_st_q  <= TX_START;
`ifdef UART_PARITY_EN
                tx_par_q <= (^fifo_rd_data) ^ ODD_BIT;
`endif
            end else begin
                unique case (tx_st_q)
                    TX_IDLE: tx_q <= 1'b1;
                    TX_START: begin
                        if (tx_cnt_q == '0) begin
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_cnt_q <= DIV_M1;
                            tx_bit_q <= '0;
                            tx_st_q  <= TX_DATA;
                        end else begin
                            tx_cnt_q <= tx_cnt_q - 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_cnt_q == '0) begin
                            tx_cnt_q <= DIV_M1;
                            if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                tx_q    <= tx_par_q;
                                tx_st_q <= TX_PARITY;
`else
                                tx_q    <= 1'b1;
                                tx_st_q <= TX_STOP;
`endif
                            end else begin
                                tx_q     <= tx_sh_q[0];
                                tx_sh_q  <= tx_sh_q >> 1;
                                tx_bit_q <= tx_bit_q + 1'b1;
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q - 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        if (tx_cnt_q == '0) begin
                            tx_q     <= 1'b1;
                            tx_cnt_q <= DIV_M1;
                            tx_st_q  <= TX_STOP;
                        end else begin
                            tx_cnt_q <= tx_cnt_q - 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (tx_cnt_q == '0) tx_st_q  <= TX_IDLE;
                        else                tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                    default: tx_st_q <= TX_IDLE;
                endcase
            end
        end
    end

    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_fifo_loop_param.sv
// Scoreboard bench for uart_fifo_loop_param (16 clocks per bit, depth 4).
// Build with UART_PARITY_EN to exercise the parity frame format.
module tb_uart_fifo_loop_param;

    localparam int CLK_HZ = 160_000;
    localparam int BAUD   = 10_000;
    localparam int BD     = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;
    localparam bit ODD    = 1'b0;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BD;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tx_en;
    logic       ovf_clr;
    logic       tx;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   frames_seen = 0;
    int   fe_cnt = 0;
    int   pe_cnt = 0;
    bit   mon_busy = 1'b0;
    bit   mon_off = 1'b0;
    logic unused_par;

    always #5 clk = ~clk;

    uart_fifo_loop_param #(
        .CLK_FREQ   (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (int'(ODD))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .tx_en      (tx_en),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
    end

    // Monitor: decode every frame on tx and compare with the scoreboard.
    initial begin : monitor
        logic       prev;
        logic       s0;
        logic       pb;
        logic       sb;
        logic [7:0] d;
        int         start;
        int         last_start;
        exp_t       e;
        prev = 1'b1;
        last_start = -100000;
        forever begin
            @(negedge clk);
            if (!mon_off && rst_n && prev && !tx) begin
                mon_busy = 1'b1;
                start = cyc;
                repeat (BD / 2) @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    d[i] = tx;
                end
                pb = 1'b0;
`ifdef UART_PARITY_EN
                repeat (BD) @(negedge clk);
                pb = tx;
`endif
                repeat (BD) @(negedge clk);
                sb = tx;
                frames_seen++;
                chk("frame_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("start_bit", s0, 0);
                    chk("echo_data", d, e.d);
                    chk("stop_bit", sb, 1);
`ifdef UART_PARITY_EN
                    chk("parity_bit", pb, (^e.d) ^ ODD);
`endif
                    if (e.gap >= 0) chk("back_to_back", start - last_start, e.gap);
                end
                last_start = start;
                prev = 1'b1;
                mon_busy = 1'b0;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic bad_par);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BD) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ ODD ^ bad_par;
        repeat (BD) @(negedge clk);
`else
        unused_par = bad_par;
`endif
        rx = stop_b;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_byte(input logic [7:0] d, input int gap);
        exp_t e;
        e.d = d;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((q.size() != 0 || mon_busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin : stim
        int f0;
        int fe0;
        int pe0;
        int n;
        rst_n = 1'b0;
        rx = 1'b1;
        tx_en = 1'b1;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single echo with latency check: count 0->1 at S+2, tx low at S+3.
        expect_byte(8'hA5, -1);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                int k;
                k = 0;
                while (fifo_count != 3'd1 && k < FRAME * 2) begin
                    @(negedge clk);
                    k++;
                end
                chk("a5_count_up", fifo_count, 1);
                @(negedge clk);
                chk("a5_tx_start", tx, 0);
                chk("a5_count_down", fifo_count, 0);
            end
        join
        wait_drain(FRAME * 4);

        // Gated burst then release.
        tx_en = 1'b0;
        f0 = frames_seen;
        for (int i = 1; i <= 4; i++) begin
            expect_byte(8'(i), (i == 1) ? -1 : FRAME);
            send_frame(8'(i), 1'b1, 1'b0);
        end
        repeat (BD) @(negedge clk);
        chk("gate_count", fifo_count, 4);
        chk("gate_tx_idle", tx, 1);
        chk("gate_no_frames", frames_seen, f0);
        chk("gate_no_ovf", overflow, 0);
        tx_en = 1'b1;
        wait_drain(FRAME * 8);

        // Overflow: fifth byte dropped.
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_byte(8'(8'h11 + i), (i == 0) ? -1 : FRAME);
            send_frame(8'(8'h11 + i), 1'b1, 1'b0);
        end
        repeat (BD) @(negedge clk);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_set", overflow, 1);
        tx_en = 1'b1;
        wait_drain(FRAME * 8);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Frame error: byte discarded, next good byte echoed.
        f0 = frames_seen;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * BD) @(negedge clk);
        chk("ferr_pulse", fe_cnt - fe0, 1);
        chk("ferr_no_perr", pe_cnt - pe0, 0);
        chk("ferr_count", fifo_count, 0);
        chk("ferr_no_echo", frames_seen, f0);
        chk("ferr_tx_idle", tx, 1);
        expect_byte(8'h55, -1);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain(FRAME * 4);

        // Single-cycle glitch: no push, no error.
        f0 = frames_seen;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (2 * BD) @(negedge clk);
        chk("glitch_no_ferr", fe_cnt, fe0);
        chk("glitch_no_perr", pe_cnt, pe0);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_no_echo", frames_seen, f0);
        expect_byte(8'h5A, -1);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_drain(FRAME * 4);

`ifdef UART_PARITY_EN
        f0 = frames_seen;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (2 * BD) @(negedge clk);
        chk("perr_pulse", pe_cnt - pe0, 1);
        chk("perr_no_ferr", fe_cnt, fe0);
        chk("perr_count", fifo_count, 0);
        chk("perr_no_echo", frames_seen, f0);
        expect_byte(8'h07, -1);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain(FRAME * 4);
        chk("perr_total", pe_cnt, 1);
`else
        chk("perr_never", pe_cnt, 0);
`endif

        // Reset in the middle of a transmitted frame.
        mon_off = 1'b1;
        tx_en = 1'b0;
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (BD) @(negedge clk);
        chk("pre_rst_count", fifo_count, 2);
        tx_en = 1'b1;
        n = 0;
        while (tx != 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_tx_low", tx, 0);
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_count", fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BD) @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_count", fifo_count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
